pg_phase_acc: RTL

Per-slot phase accumulator for the OPM phase generator. It sits directly upstream of the recirculating EBR delay line that holds the 32 slot phases. Each enabled cycle it consumes one slot's phase from the delay line output and applies key-on reset, hold or increment. It writes the result back into the delay line input and forwards the top phase bits to the operator stage.

---
 rtl/pg_phase_acc.sv | 106 ++++++++++
 1 files changed

// File: rtl/pg_phase_acc.sv
// pg_phase_acc
// Per-slot phase accumulator for the OPM phase generator. It sits in front of
// the recirculating delay line that stores the phase of every slot. On each
// enabled beat it takes one slot's stored phase and applies key-on reset, hold
// or increment. The result goes back into the delay line. The top phase bits
// are forwarded to the operator stage.
//
// Ports:
//   clk        clock
//   rst        asynchronous, active-high reset
//   cen        clock enable; one slot per enabled cycle
//   sync_in    marks the slot-0 beat on ph_in
//   ph_in      stored phase from the delay line output
//   inc        phase increment for the slot on ph_in (zero-extended)
//   keyon_rst  clear the phase of the slot on ph_in
//   hold       test-mode freeze: no advance for any slot
//   ph_out     updated phase to the delay line input
//   op_phase   top OUT_W bits of ph_out, to the operator
//   slot_out   slot index carried by ph_out
//   sync_out   high while ph_out carries slot 0
//   sync_err   sticky flag: sync_in arrived off-frame
module pg_phase_acc #(
    parameter int PH_W  = 20,
    parameter int INC_W = 17,
    parameter int OUT_W = 10,
    parameter int SLOTS = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cen,
    input  logic                     sync_in,
    input  logic [PH_W-1:0]          ph_in,
    input  logic [INC_W-1:0]         inc,
    input  logic                     keyon_rst,
    input  logic                     hold,
    output logic [PH_W-1:0]          ph_out,
    output logic [OUT_W-1:0]         op_phase,
    output logic [$clog2(SLOTS)-1:0] slot_out,
    output logic                     sync_out,
    output logic                     sync_err
);

    localparam int SL_W = $clog2(SLOTS);

    logic [SL_W-1:0]  slot_cnt;
    logic [SL_W-1:0]  slot_nxt;
    logic [SL_W-1:0]  slot_use;

    logic [PH_W-1:0]  s1_ph;
    logic [INC_W-1:0] s1_inc;
    logic             s1_key;
    logic             s1_hold;
    logic [SL_W-1:0]  s1_slot;

    logic [PH_W-1:0]  ph_nxt;

    // SLOTS is a power of two, so the counter wraps naturally.
    // A sync beat is always slot 0, and counting continues from there.
    always_comb begin
        slot_nxt = slot_cnt + SL_W'(1);
        slot_use = sync_in ? '0 : slot_nxt;
    end

    // Priority: keyon_rst > hold > increment. The sum wraps with no carry out.
    always_comb begin
        ph_nxt = s1_ph + PH_W'(s1_inc);
        if (s1_hold)
            ph_nxt = s1_ph;
        if (s1_key)
            ph_nxt = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Reset to the last slot so the first beat without sync is slot 0.
            slot_cnt <= SL_W'(SLOTS - 1);
            s1_ph    <= '0;
            s1_inc   <= '0;
            s1_key   <= 1'b0;
            s1_hold  <= 1'b0;
            s1_slot  <= '0;
            ph_out   <= '0;
            slot_out <= '0;
            sync_out <= 1'b0;
            sync_err <= 1'b0;
        end else if (cen) begin
            slot_cnt <= slot_use;
            s1_ph    <= ph_in;
            s1_inc   <= inc;
            s1_key   <= keyon_rst;
            s1_hold  <= hold;
            s1_slot  <= slot_use;

            ph_out   <= ph_nxt;
            slot_out <= s1_slot;
            sync_out <= (s1_slot == '0);

            // The resync above still takes effect on the beat that flags it.
            if (sync_in && (slot_nxt != '0))
                sync_err <= 1'b1;
        end
    end

    assign op_phase = ph_out[PH_W-1 -: OUT_W];

endmodule
